sp_unit: RTL and testbench
==========================

// Module: sp_unit
// PURPOSE
//  Parametrised stack-pointer unit for the SCP core. It is the next generation of the plain SP register.
//  Holds SP and supports inc/dec, signed-offset adjust, bus/secondary loads and bounds checking with wrap/trap mode.
//  Adds a shadow LIFO that saves/restores SP on interrupt entry/return.
//  Sits in the register file; driven by the control unit, and val feeds the address mux.
// PARAMETERS
//  WIDTH        16  SP width in bits
//  RESET_VAL    0   val after reset
//  SHADOW_DEPTH 4   shadow LIFO entries (>=1)
//  TRAP_MODE    1   1: out-of-bounds inc/dec/adj holds val; 0: val takes wrapped result
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      asynchronous, active-high reset
//  val         out  WIDTH  current stack pointer (registered)
//  bus_in      in   WIDTH  load value, main bus
//  bus_we      in   1      load val from bus_in
//  sec_in      in   WIDTH  load value, secondary bus
//  sec_we      in   1      load val from sec_in
//  inc / dec   in   1      val +1 / val -1
//  adj         in   1      val + adj_off
//  adj_off     in   WIDTH  signed two's-complement offset
//  lim_lo      in   WIDTH  lowest legal SP (unsigned, inclusive)
//  lim_hi      in   WIDTH  highest legal SP (unsigned, inclusive)
//  save        in   1      push current val onto shadow LIFO
//  restore     in   1      pop shadow top into val
//  clr_flags   in   1      clear sticky flags
//  shadow_cnt  out  $clog2(SHADOW_DEPTH+1)  occupied shadow entries
//  ovf / unf   out  1      sticky: checked op exceeded lim_hi / went below lim_lo
//  shd_err     out  1      sticky: save when full, or restore when empty
//  fault       out  1      one-cycle pulse on any ovf/unf/shd_err event
// BEHAVIOUR
//  - Reset (async, dominates everything): val=RESET_VAL, shadow_cnt=0, ovf=unf=shd_err=fault=0.
//    Shadow contents are not reset and are don't-care. Reset mid-operation discards the pending op.
//  - Latency: one request -> val/flags/fault update at the next posedge. No multicycle ops.
//  - val priority, highest first: sec_we > bus_we > restore > adj > dec > inc. Only the winner takes effect.
//  - Bounds check applies only to inc/dec/adj. Compute r in WIDTH+2 signed bits: zero-extend val, sign-extend offset.
//    r>lim_hi or r>2^WIDTH-1 -> ovf; r<lim_lo or r<0 -> unf. Loads and restore are never checked.
//  - On violation: TRAP_MODE=1 holds val; TRAP_MODE=0 loads r[WIDTH-1:0]. Both modes set the flag and pulse fault.
//  - Shadow save captures pre-update val, independent of which op wins val. Save with cnt==SHADOW_DEPTH
//    -> shd_err, no push.
//  - Restore when cnt==0 -> shd_err; val keeps lower-priority result or holds.
//  - save & restore in same cycle, cnt>0 -> swap: val<=top, top<=old val, cnt unchanged.
//    With cnt==0 -> shd_err, nothing pushed.
//  - Restore that loses priority to bus_we/sec_we still pops (entry discarded).
//  - clr_flags clears ovf/unf/shd_err. A new event in the same cycle wins (flag stays set).
//  - fault is high for exactly the cycle after an event. Back-to-back events keep it high.
// STRUCTURE
//  - Package sp_pkg: op enum (OP_NONE, OP_INC, OP_DEC, OP_ADJ, OP_RST, OP_BUS, OP_SEC),
//    priority encode function, bounds-check result struct {ovf, unf}.
//  - Sub-module sp_shadow_lifo: SHADOW_DEPTH x WIDTH LIFO with push/pop/swap, count, full/empty.
//    Async reset clears count only.
//  - Top: priority encoder, adder/bounds checker, val register, flag registers.
// TESTING
//  1. val=0x1234, assert rst between edges -> val=0x0000 immediately; shadow_cnt=0; all flags 0.
//  2. inc=dec=bus_we=sec_we=1, bus_in=0x0100, sec_in=0x0200 -> val=0x0200.
//     Next cycle inc=dec=1 -> val=0x01FF.
//  3. lim_hi=0x00FF, val=0x00FF, inc: TRAP_MODE=1 -> val=0x00FF, ovf=1, fault 1 cycle.
//     TRAP_MODE=0 -> val=0x0100, ovf=1.
//  4. val=0x0010, lim_lo=0x0008, adj_off=0xFFF0 -> unf=1, val=0x0010 (trap).
//     clr_flags, then adj_off=0xFFF8 -> val=0x0008, unf=0, fault=0.
//  5. save at val=0x10,0x20,0x30,0x40 -> cnt=4; 5th save -> shd_err=1, cnt=4.
//     4 restores -> val 0x40,0x30,0x20,0x10; 5th restore -> shd_err pulse, val=0x10.
//  6. cnt=2, top=0x20, val=0x55, save+restore -> val=0x20, top=0x55, cnt=2.
//     Next restore -> val=0x55.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared types for the stack-pointer unit: operation encoding, the val-source
// priority encoder, and the bounds-check result.
package sp_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_DEC,
        OP_ADJ,
        OP_RST,
        OP_BUS,
        OP_SEC
    } op_e;

    typedef struct packed {
        logic ovf;
        logic unf;
    } bnd_t;

    // rst_req must already be qualified with "shadow not empty", so that an
    // empty restore falls through to the lower-priority ops.
    function automatic op_e sp_prio(input logic sec_we, input logic bus_we,
                                    input logic rst_req, input logic adj,
                                    input logic dec, input logic inc);
        op_e op;
        if (sec_we)       op = OP_SEC;
        else if (bus_we)  op = OP_BUS;
        else if (rst_req) op = OP_RST;
        else if (adj)     op = OP_ADJ;
        else if (dec)     op = OP_DEC;
        else if (inc)     op = OP_INC;
        else              op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/sp_shadow_lifo.sv
// Shadow LIFO holding saved SP values. Push and pop together swap the top entry.
// Reset clears only the occupancy count; entry contents are left as they were.
module sp_shadow_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               din_i,
    output logic [WIDTH-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0]     cnt_o,
    output logic                           full_o,
    output logic                           empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_m1;
    logic [AW-1:0]    wr_idx, top_idx;

    assign cnt_m1  = cnt_q - CW'(1);
    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = cnt_m1[AW-1:0];

    assign top_o   = mem_q[top_idx];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i)
            cnt_d = cnt_q + CW'(1);
        else if (pop_i && !push_i)
            cnt_d = cnt_m1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Swap overwrites the current top; a plain push writes the next free slot.
    always_ff @(posedge clk) begin
        if (push_i && pop_i)
            mem_q[top_idx] <= din_i;
        else if (push_i)
            mem_q[wr_idx] <= din_i;
    end

endmodule

// File: rtl/sp_unit.sv
// Stack-pointer register with inc/dec/offset adjust, bus loads, bounds checking
// (trap or wrap) and a shadow LIFO for interrupt save/restore.
module sp_unit
    import sp_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int          SHADOW_DEPTH = 4,
    parameter int          TRAP_MODE    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic [WIDTH-1:0]                       val,
    input  logic [WIDTH-1:0]                       bus_in,
    input  logic                                   bus_we,
    input  logic [WIDTH-1:0]                       sec_in,
    input  logic                                   sec_we,
    input  logic                                   inc,
    input  logic                                   dec,
    input  logic                                   adj,
    input  logic [WIDTH-1:0]                       adj_off,
    input  logic [WIDTH-1:0]                       lim_lo,
    input  logic [WIDTH-1:0]                       lim_hi,
    input  logic                                   save,
    input  logic                                   restore,
    input  logic                                   clr_flags,
    output logic [$clog2(SHADOW_DEPTH+1)-1:0]      shadow_cnt,
    output logic                                   ovf,
    output logic                                   unf,
    output logic                                   shd_err,
    output logic                                   fault
);
    logic [WIDTH-1:0] val_q, val_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             shd_err_q, shd_err_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] shd_top;
    logic             shd_full, shd_empty;
    logic             shd_push, shd_pop;

    op_e              op;
    logic             checked;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] r;
    logic             r_neg, r_big;
    bnd_t             bnd;
    logic             ev_ovf, ev_unf, ev_shd;

    assign op      = sp_prio(sec_we, bus_we, restore & ~shd_empty, adj, dec, inc);
    assign checked = (op == OP_INC) || (op == OP_DEC) || (op == OP_ADJ);

    // r is a WIDTH+2 bit two's-complement sum: bit W+1 = negative, bit W = above 2^WIDTH-1.
    always_comb begin
        addend = '0;
        case (op)
            OP_INC:  addend = {{(WIDTH+1){1'b0}}, 1'b1};
            OP_DEC:  addend = '1;
            OP_ADJ:  addend = {{2{adj_off[WIDTH-1]}}, adj_off};
            default: addend = '0;
        endcase
    end

    assign r     = {2'b00, val_q} + addend;
    assign r_neg = r[WIDTH+1];
    assign r_big = ~r[WIDTH+1] & r[WIDTH];

    always_comb begin
        bnd.ovf = ~r_neg & (r_big | (r[WIDTH-1:0] > lim_hi));
        bnd.unf = r_neg | (~r_big & (r[WIDTH-1:0] < lim_lo));
    end

    assign ev_ovf = checked & bnd.ovf;
    assign ev_unf = checked & bnd.unf;
    assign ev_shd = (save & ~restore & shd_full) | (restore & shd_empty);

    assign shd_push = save & (restore ? ~shd_empty : ~shd_full);
    assign shd_pop  = restore & ~shd_empty;

    always_comb begin
        val_d = val_q;
        case (op)
            OP_SEC: val_d = sec_in;
            OP_BUS: val_d = bus_in;
            OP_RST: val_d = shd_top;
            OP_INC, OP_DEC, OP_ADJ: begin
                if (!((bnd.ovf || bnd.unf) && (TRAP_MODE != 0)))
                    val_d = r[WIDTH-1:0];
            end
            default: val_d = val_q;
        endcase
    end

    always_comb begin
        ovf_d     = ev_ovf | (ovf_q & ~clr_flags);
        unf_d     = ev_unf | (unf_q & ~clr_flags);
        shd_err_d = ev_shd | (shd_err_q & ~clr_flags);
        fault_d   = ev_ovf | ev_unf | ev_shd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q     <= RESET_VAL;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            shd_err_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            val_q     <= val_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            shd_err_q <= shd_err_d;
            fault_q   <= fault_d;
        end
    end

    sp_shadow_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .push_i  (shd_push),
        .pop_i   (shd_pop),
        .din_i   (val_q),
        .top_o   (shd_top),
        .cnt_o   (shadow_cnt),
        .full_o  (shd_full),
        .empty_o (shd_empty)
    );

    assign val     = val_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign shd_err = shd_err_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_sp_unit.sv
// Directed bench for sp_unit: a trapping and a wrapping instance share stimulus.
module tb_sp_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in, sec_in, adj_off, lim_lo, lim_hi;
    logic        bus_we, sec_we, inc, dec, adj, save, restore, clr_flags;

    logic [15:0] val_t, val_w;
    logic [2:0]  cnt_t, cnt_w;
    logic        ovf_t, unf_t, shd_t, fault_t;
    logic        ovf_w, unf_w, shd_w, fault_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp_unit #(.WIDTH(16), .RESET_VAL(16'h0000), .SHADOW_DEPTH(4), .TRAP_MODE(1)) dut_t (
        .clk(clk), .rst(rst), .val(val_t), .bus_in(bus_in), .bus_we(bus_we),
        .sec_in(sec_in), .sec_we(sec_we), .inc(inc), .dec(dec), .adj(adj),
        .adj_off(adj_off), .lim_lo(lim_lo), .lim_hi(lim_hi), .save(save),
        .restore(restore), .clr_flags(clr_flags), .shadow_cnt(cnt_t),
        .ovf(ovf_t), .unf(unf_t), .shd_err(shd_t), .fault(fault_t)
    );

    sp_unit #(.WIDTH(16), .RESET_VAL(16'h0000), .SHADOW_DEPTH(4), .TRAP_MODE(0)) dut_w (
        .clk(clk), .rst(rst), .val(val_w), .bus_in(bus_in), .bus_we(bus_we),
        .sec_in(sec_in), .sec_we(sec_we), .inc(inc), .dec(dec), .adj(adj),
        .adj_off(adj_off), .lim_lo(lim_lo), .lim_hi(lim_hi), .save(save),
        .restore(restore), .clr_flags(clr_flags), .shadow_cnt(cnt_w),
        .ovf(ovf_w), .unf(unf_w), .shd_err(shd_w), .fault(fault_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus_we = 0; sec_we = 0; inc = 0; dec = 0; adj = 0;
        save = 0; restore = 0; clr_flags = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [15:0] v);
        bus_in = v; bus_we = 1;
        tick();
    endtask

    initial begin
        logic [15:0] exp_pop [4];
        logic [15:0] pushes [3];

        rst = 1;
        bus_in = 0; sec_in = 0; adj_off = 0; lim_lo = 16'h0000; lim_hi = 16'hFFFF;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: async reset mid-cycle clears val, count and flags
        bus_in = 16'h1234; bus_we = 1; save = 1;
        tick();
        chk("t1_load_val", val_t, 16'h1234);
        chk("t1_load_cnt", cnt_t, 1);
        #2 rst = 1;
        #1;
        chk("t1_rst_val", val_t, 16'h0000);
        chk("t1_rst_val_w", val_w, 16'h0000);
        chk("t1_rst_cnt", cnt_t, 0);
        chk("t1_rst_flags", {ovf_t, unf_t, shd_t, fault_t}, 4'b0000);
        @(negedge clk) rst = 0;

        // 2: priority sec > bus > dec > inc
        bus_in = 16'h0100; bus_we = 1; sec_in = 16'h0200; sec_we = 1; inc = 1; dec = 1;
        tick();
        chk("t2_sec_wins", val_t, 16'h0200);
        inc = 1; dec = 1;
        tick();
        chk("t2_dec_wins", val_t, 16'h01FF);
        chk("t2_no_fault", fault_t, 0);

        // 3: overflow against lim_hi, trap vs wrap
        lim_hi = 16'h00FF;
        load(16'h00FF);
        inc = 1;
        tick();
        chk("t3_trap_val", val_t, 16'h00FF);
        chk("t3_wrap_val", val_w, 16'h0100);
        chk("t3_trap_ovf", ovf_t, 1);
        chk("t3_wrap_ovf", ovf_w, 1);
        chk("t3_fault", fault_t, 1);
        chk("t3_fault_w", fault_w, 1);
        tick();
        chk("t3_fault_pulse", fault_t, 0);
        chk("t3_ovf_sticky", ovf_t, 1);
        clr_flags = 1;
        tick();
        chk("t3_ovf_clr", ovf_t, 0);
        // overflow past 2^WIDTH-1 with lim_hi at max
        lim_hi = 16'hFFFF;
        load(16'hFFFF);
        inc = 1;
        tick();
        chk("t3_top_trap_val", val_t, 16'hFFFF);
        chk("t3_top_wrap_val", val_w, 16'h0000);
        chk("t3_top_ovf", ovf_t, 1);
        clr_flags = 1;
        tick();

        // 4: underflow via negative adjust
        lim_lo = 16'h0008;
        load(16'h0010);
        adj = 1; adj_off = 16'hFFF0;
        tick();
        chk("t4_unf", unf_t, 1);
        chk("t4_unf_w", unf_w, 1);
        chk("t4_trap_val", val_t, 16'h0010);
        chk("t4_wrap_val", val_w, 16'h0000);
        clr_flags = 1;
        tick();
        chk("t4_unf_clr", unf_t, 0);
        adj = 1; adj_off = 16'hFFF8;
        tick();
        chk("t4_adj_val", val_t, 16'h0008);
        chk("t4_adj_unf", unf_t, 0);
        chk("t4_adj_fault", fault_t, 0);
        // new event beats clr_flags in the same cycle
        dec = 1; clr_flags = 1;
        tick();
        chk("t4_lo_hold", val_t, 16'h0008);
        chk("t4_evt_wins_clr", unf_t, 1);
        lim_lo = 16'h0000; clr_flags = 1;
        tick();

        // 5: fill shadow, overflow it, drain it, underflow it
        load(16'h0010);
        pushes[0] = 16'h0020; pushes[1] = 16'h0030; pushes[2] = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            save = 1; bus_in = pushes[i]; bus_we = 1;
            tick();
        end
        save = 1;
        tick();
        chk("t5_cnt_full", cnt_t, 4);
        chk("t5_cnt_full_w", cnt_w, 4);
        save = 1;
        tick();
        chk("t5_save_full_err", shd_t, 1);
        chk("t5_save_full_err_w", shd_w, 1);
        chk("t5_save_full_cnt", cnt_t, 4);
        chk("t5_save_full_fault", fault_t, 1);
        clr_flags = 1;
        tick();
        exp_pop[0] = 16'h0040; exp_pop[1] = 16'h0030; exp_pop[2] = 16'h0020; exp_pop[3] = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            restore = 1;
            tick();
            chk($sformatf("t5_pop%0d", i), val_t, exp_pop[i]);
        end
        chk("t5_cnt_empty", cnt_t, 0);
        chk("t5_no_err_yet", shd_t, 0);
        restore = 1;
        tick();
        chk("t5_pop_empty_err", shd_t, 1);
        chk("t5_pop_empty_fault", fault_t, 1);
        chk("t5_pop_empty_val", val_t, 16'h0010);
        clr_flags = 1;
        tick();

        // 6: swap on save+restore, then a pop that loses val priority
        load(16'h0010);
        save = 1; bus_in = 16'h0020; bus_we = 1;
        tick();
        save = 1; bus_in = 16'h0055; bus_we = 1;
        tick();
        chk("t6_pre_cnt", cnt_t, 2);
        save = 1; restore = 1;
        tick();
        chk("t6_swap_val", val_t, 16'h0020);
        chk("t6_swap_cnt", cnt_t, 2);
        restore = 1;
        tick();
        chk("t6_after_swap_val", val_t, 16'h0055);
        chk("t6_after_swap_cnt", cnt_t, 1);
        restore = 1; bus_in = 16'h0077; bus_we = 1;
        tick();
        chk("t6_bus_beats_pop_val", val_t, 16'h0077);
        chk("t6_pop_discard_cnt", cnt_t, 0);
        chk("t6_no_shd_err", shd_t, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
